// File: rtl/tap_move_sequencer.sv
// TAP move sequencer: walks the 1149.1 TAP FSM to a requested stable
// state, emitting one TMS bit per step and tracking a shadow TAP state.
module tap_move_sequencer #(
   parameter int unsigned LEN_W    = 8,
   parameter bit          CHECK_EN = 1'b1
) (
   input  logic             GCLK,
   input  logic             TRST_n,
   input  logic             req,
   input  logic [3:0]       target_state,
   input  logic [LEN_W-1:0] shift_len,
   input  logic [3:0]       obs_state,
   output logic             tck_en,
   output logic             tms_out,
   output logic             busy,
   output logic             done,
   output logic             cmd_err,
   output logic             obs_err,
   output logic [3:0]       cur_state
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_FORCE,
      S_DWELL,
      S_DONE
   } fsm_e;

   localparam logic [3:0] TLR    = 4'h0;
   localparam logic [3:0] RTI    = 4'h1;
   localparam logic [3:0] SEL_DR = 4'h2;
   localparam logic [3:0] CAP_DR = 4'h3;
   localparam logic [3:0] SH_DR  = 4'h4;
   localparam logic [3:0] EX1_DR = 4'h5;
   localparam logic [3:0] PAU_DR = 4'h6;
   localparam logic [3:0] EX2_DR = 4'h7;
   localparam logic [3:0] UPD_DR = 4'h8;
   localparam logic [3:0] SEL_IR = 4'h9;
   localparam logic [3:0] CAP_IR = 4'hA;
   localparam logic [3:0] SH_IR  = 4'hB;
   localparam logic [3:0] EX1_IR = 4'hC;
   localparam logic [3:0] PAU_IR = 4'hD;
   localparam logic [3:0] EX2_IR = 4'hE;
   localparam logic [3:0] UPD_IR = 4'hF;

   function automatic logic [3:0] tap_next(
      input logic [3:0] s,
      input logic       tms
   );
      logic [3:0] n;
      n = TLR;
      case (s)
         TLR:           n = tms ? TLR    : RTI;
         RTI:           n = tms ? SEL_DR : RTI;
         SEL_DR:        n = tms ? SEL_IR : CAP_DR;
         CAP_DR, SH_DR: n = tms ? EX1_DR : SH_DR;
         EX1_DR:        n = tms ? UPD_DR : PAU_DR;
         PAU_DR:        n = tms ? EX2_DR : PAU_DR;
         EX2_DR:        n = tms ? UPD_DR : SH_DR;
         UPD_DR,
         UPD_IR:        n = tms ? SEL_DR : RTI;
         SEL_IR:        n = tms ? TLR    : CAP_IR;
         CAP_IR, SH_IR: n = tms ? EX1_IR : SH_IR;
         EX1_IR:        n = tms ? UPD_IR : PAU_IR;
         PAU_IR:        n = tms ? EX2_IR : PAU_IR;
         EX2_IR:        n = tms ? UPD_IR : SH_IR;
      endcase
      return n;
   endfunction

   function automatic logic tms_rule(
      input logic [3:0] s,
      input logic [3:0] t
   );
      logic b;
      b = 1'b1;
      case (s)
         TLR:            b = 1'b0;
         RTI:            b = 1'b1;
         SEL_DR:         b = !(t == SH_DR || t == PAU_DR);
         SEL_IR:         b = !(t == SH_IR || t == PAU_IR);
         CAP_DR, EX2_DR: b = (t != SH_DR);
         CAP_IR, EX2_IR: b = (t != SH_IR);
         EX1_DR:         b = (t != PAU_DR);
         EX1_IR:         b = (t != PAU_IR);
         UPD_DR, UPD_IR: b = (t != RTI);
         SH_DR, SH_IR,
         PAU_DR, PAU_IR: b = 1'b1;
      endcase
      return b;
   endfunction

   function automatic logic is_legal(input logic [3:0] t);
      return t inside {TLR, RTI, SH_DR, PAU_DR, SH_IR, PAU_IR};
   endfunction

   function automatic logic dwell_ok(input logic [3:0] t);
      return t inside {RTI, SH_DR, SH_IR};
   endfunction

   fsm_e             state_q, state_d;
   logic [3:0]       tgt_q, tgt_d;
   logic [LEN_W-1:0] dwell_q, dwell_d;
   logic [2:0]       force_q, force_d;
   logic             chk_q, chk_d;
   logic             tck_q, tck_d;
   logic             tms_q, tms_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cerr_q, cerr_d;
   logic             oerr_q, oerr_d;
   logic [3:0]       cur_q, cur_d;

   logic [3:0]       s_eff;
   logic             go_arr;
   logic [LEN_W-1:0] len_v;

   always_comb begin
      // Shadow state once the step currently on the TAP has landed.
      s_eff   = tck_q ? tap_next(cur_q, tms_q) : cur_q;
      state_d = state_q;
      tgt_d   = tgt_q;
      dwell_d = dwell_q;
      force_d = force_q;
      tck_d   = 1'b0;
      tms_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cerr_d  = 1'b0;
      cur_d   = s_eff;
      chk_d   = tck_q & ~(state_q == S_FORCE && force_q != 3'd0);
      oerr_d  = oerr_q |
                (CHECK_EN & chk_q & (obs_state != cur_q));
      go_arr  = 1'b0;
      len_v   = dwell_q;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               tgt_d   = target_state;
               dwell_d = shift_len;
               len_v   = shift_len;
               busy_d  = 1'b1;
               if (!is_legal(target_state)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  cerr_d  = 1'b1;
               end else if (target_state == TLR) begin
                  state_d = S_FORCE;
                  tck_d   = 1'b1;
                  tms_d   = 1'b1;
                  force_d = 3'd4;
               end else if (s_eff != target_state) begin
                  state_d = S_MOVE;
                  tck_d   = 1'b1;
                  tms_d   = tms_rule(s_eff, target_state);
               end else begin
                  go_arr = 1'b1;
               end
            end
         end
         S_MOVE: begin
            if (s_eff != tgt_q) begin
               tck_d = 1'b1;
               tms_d = tms_rule(s_eff, tgt_q);
            end else begin
               go_arr = 1'b1;
            end
         end
         S_FORCE: begin
            if (force_q != 3'd0) begin
               tck_d   = 1'b1;
               tms_d   = 1'b1;
               force_d = force_q - 3'd1;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DWELL: begin
            if (dwell_q != '0) begin
               tck_d   = 1'b1;
               dwell_d = dwell_q - LEN_W'(1);
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (go_arr) begin
         if (dwell_ok(tgt_d) && len_v != '0) begin
            state_d = S_DWELL;
            tck_d   = 1'b1;
            dwell_d = len_v - LEN_W'(1);
         end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge GCLK) begin
      if (!TRST_n) begin
         state_q <= S_IDLE;
         tgt_q   <= TLR;
         dwell_q <= '0;
         force_q <= 3'd0;
         chk_q   <= 1'b0;
         tck_q   <= 1'b0;
         tms_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cerr_q  <= 1'b0;
         oerr_q  <= 1'b0;
         cur_q   <= TLR;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         dwell_q <= dwell_d;
         force_q <= force_d;
         chk_q   <= chk_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cerr_q  <= cerr_d;
         oerr_q  <= oerr_d;
         cur_q   <= cur_d;
      end
   end

   assign tck_en    = tck_q;
   assign tms_out   = tms_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_err   = cerr_q;
   assign obs_err   = oerr_q;
   assign cur_state = cur_q;

endmodule
